// File: rtl/jstk_frame_scheduler_pkg.sv
// jstk_frame_scheduler_pkg: shared command bytes, frame length, FSM states and tx byte selection
// No ports. Imported by the scheduler top.
package jstk_frame_scheduler_pkg;
    localparam logic [7:0] CMD_SET_LED = 8'h84;
    localparam logic [7:0] CMD_NOP = 8'h00;
    localparam int FRAME_BYTES = 5;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT_RX,
        ST_GAP,
        ST_HOLD
    } state_e;
    // A read frame is all NOPs; an LED frame is 0x84, R, G, B, 0x00.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic led, input logic [23:0] rgb);
        return !led ? CMD_NOP :
               idx == 3'd0 ? CMD_SET_LED :
               idx == 3'd1 ? rgb[23:16] :
               idx == 3'd2 ? rgb[15:8] :
               idx == 3'd3 ? rgb[7:0] : CMD_NOP;
    endfunction
endpackage

// File: rtl/jstk_frame_scheduler_if.sv
// jstk_frame_scheduler_if: slave select plus byte-level tx/rx handshake to the SPI shifter
// Signals: ss_n, tx_byte/tx_valid (to shifter), tx_ready, rx_byte/rx_valid (from shifter).
// master = scheduler side, slave = shifter side.
interface jstk_frame_scheduler_if;
    logic       ss_n;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    modport master (output ss_n, tx_byte, tx_valid, input tx_ready, rx_byte, rx_valid);
    modport slave (input ss_n, tx_byte, tx_valid, output tx_ready, rx_byte, rx_valid);
endinterface

// File: rtl/jstk_delay_timer.sv
// jstk_delay_timer: loadable down-counter shared by the setup, gap and hold intervals
// Ports: clk, rst, load_i (load value_i), value_i, done_o (count has reached zero).
module jstk_delay_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);
    logic [W-1:0] val_q, val_d;
    assign done_o = val_q == '0;
    always_comb val_d = load_i ? value_i : done_o ? val_q : val_q - 1'b1;
    always_ff @(posedge clk) begin
        if (rst) val_q <= '0;
        else val_q <= val_d;
    end
endmodule

// File: rtl/jstk_frame_scheduler.sv
// jstk_frame_scheduler: issues one 5-byte PmodJSTK2 frame per period and unpacks the joystick reply
// Ports: clk, rst, rgb_color_i (requested colour), spi (master side of the shifter link),
//        joy_x_o/joy_y_o/joy_btn_o (last sample), pos_valid_o, led_sent_o, busy_o.
module jstk_frame_scheduler
    import jstk_frame_scheduler_pkg::*;
#(
    parameter int FRAME_CYCLES    = 120000,
    parameter int SS_SETUP_CYCLES = 300,
    parameter int BYTE_GAP_CYCLES = 120,
    parameter int SS_HOLD_CYCLES  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [23:0]            rgb_color_i,
    jstk_frame_scheduler_if.master spi,
    output logic [9:0]             joy_x_o,
    output logic [9:0]             joy_y_o,
    output logic [1:0]             joy_btn_o,
    output logic                   pos_valid_o,
    output logic                   led_sent_o,
    output logic                   busy_o
);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int TMAX = SS_SETUP_CYCLES > BYTE_GAP_CYCLES ?
        (SS_SETUP_CYCLES > SS_HOLD_CYCLES ? SS_SETUP_CYCLES : SS_HOLD_CYCLES) :
        (BYTE_GAP_CYCLES > SS_HOLD_CYCLES ? BYTE_GAP_CYCLES : SS_HOLD_CYCLES);
    localparam int TW = $clog2(TMAX + 1);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          ss_n_q, ss_n_d, tx_valid_q, tx_valid_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [2:0]    idx_q, idx_d;
    logic [21:0]   raw_q, raw_d;
    logic [23:0]   shadow_q, shadow_d, last_q, last_d;
    logic          led_q, led_d, dirty_q, dirty_d;
    logic [9:0]    joy_x_q, joy_x_d, joy_y_q, joy_y_d;
    logic [1:0]    btn_q, btn_d;
    logic          pos_valid_q, pos_valid_d, led_sent_q, led_sent_d;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;
    // Timers are loaded with N-1 so the transition lands exactly N edges after the load.
    jstk_delay_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load_i(tmr_load),
        .value_i(tmr_val),
        .done_o(tmr_done)
    );
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_q == CW'(FRAME_CYCLES - 1) ? '0 : cnt_q + 1'b1;
    end
    always_comb begin
        state_d = state_q;
        ss_n_d = ss_n_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d = tx_byte_q;
        idx_d = idx_q;
        raw_d = raw_q;
        shadow_d = shadow_q;
        last_d = last_q;
        led_d = led_q;
        dirty_d = dirty_q;
        joy_x_d = joy_x_q;
        joy_y_d = joy_y_q;
        btn_d = btn_q;
        pos_valid_d = 1'b0;
        led_sent_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val = '0;
        case (state_q)
            ST_IDLE: if (cnt_q == '0) begin
                shadow_d = rgb_color_i;
                led_d = dirty_q || rgb_color_i != last_q;
                ss_n_d = 1'b0;
                idx_d = '0;
                tmr_load = 1'b1;
                tmr_val = TW'(SS_SETUP_CYCLES - 1);
                state_d = ST_SETUP;
            end
            ST_SETUP, ST_GAP: if (tmr_done) begin
                tx_valid_d = 1'b1;
                tx_byte_d = frame_byte(idx_q, led_q, shadow_q);
                state_d = ST_SEND;
            end
            ST_SEND: if (spi.tx_ready) begin
                tx_valid_d = 1'b0;
                state_d = ST_WAIT_RX;
            end
            ST_WAIT_RX: if (spi.rx_valid) begin
                // Only the bits that reach joy_* are kept: {b4[1:0], b3[1:0], b2, b1[1:0], b0}.
                case (idx_q)
                    3'd0: raw_d[7:0] = spi.rx_byte;
                    3'd1: raw_d[9:8] = spi.rx_byte[1:0];
                    3'd2: raw_d[17:10] = spi.rx_byte;
                    3'd3: raw_d[19:18] = spi.rx_byte[1:0];
                    default: raw_d[21:20] = spi.rx_byte[1:0];
                endcase
                tmr_load = 1'b1;
                if (idx_q < 3'(FRAME_BYTES - 1)) begin
                    idx_d = idx_q + 3'd1;
                    tmr_val = TW'(BYTE_GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    tmr_val = TW'(SS_HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: if (tmr_done) begin
                ss_n_d = 1'b1;
                pos_valid_d = 1'b1;
                joy_x_d = raw_q[9:0];
                joy_y_d = raw_q[19:10];
                btn_d = raw_q[21:20];
                last_d = led_q ? shadow_q : last_q;
                dirty_d = led_q ? 1'b0 : dirty_q;
                led_sent_d = led_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ss_n_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_byte_q <= '0;
            idx_q <= '0;
            raw_q <= '0;
            shadow_q <= '0;
            last_q <= '0;
            led_q <= 1'b0;
            dirty_q <= 1'b1;
            joy_x_q <= '0;
            joy_y_q <= '0;
            btn_q <= '0;
            pos_valid_q <= 1'b0;
            led_sent_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ss_n_q <= ss_n_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q <= tx_byte_d;
            idx_q <= idx_d;
            raw_q <= raw_d;
            shadow_q <= shadow_d;
            last_q <= last_d;
            led_q <= led_d;
            dirty_q <= dirty_d;
            joy_x_q <= joy_x_d;
            joy_y_q <= joy_y_d;
            btn_q <= btn_d;
            pos_valid_q <= pos_valid_d;
            led_sent_q <= led_sent_d;
        end
    end
    assign spi.ss_n = ss_n_q;
    assign spi.tx_valid = tx_valid_q;
    assign spi.tx_byte = tx_byte_q;
    assign joy_x_o = joy_x_q;
    assign joy_y_o = joy_y_q;
    assign joy_btn_o = btn_q;
    assign pos_valid_o = pos_valid_q;
    assign led_sent_o = led_sent_q;
    assign busy_o = state_q != ST_IDLE;
endmodule

// File: tb/tb_jstk_frame_scheduler.sv
// tb_jstk_frame_scheduler: randomized bench with an event-timed frame model and literal spot checks
module tb_jstk_frame_scheduler;
    localparam int FC = 400, SU = 8, GP = 4, HD = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic [23:0] rgb = 24'h0;
    logic [9:0] joy_x, joy_y;
    logic [1:0] joy_btn;
    logic pos_valid, led_sent, busy;
    jstk_frame_scheduler_if bus();
    jstk_frame_scheduler #(.FRAME_CYCLES(FC), .SS_SETUP_CYCLES(SU), .BYTE_GAP_CYCLES(GP), .SS_HOLD_CYCLES(HD)) dut (
        .clk(clk), .rst(rst), .rgb_color_i(rgb), .spi(bus),
        .joy_x_o(joy_x), .joy_y_o(joy_y), .joy_btn_o(joy_btn),
        .pos_valid_o(pos_valid), .led_sent_o(led_sent), .busy_o(busy)
    );
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shifter model controls
    int drv_nacc = 0, stall_byte = -1, stall_len = 0, stray_cnt = 0;
    bit fixed_rx = 0, stray_req = 0;
    logic [7:0] fixed_b [5] = '{8'h34, 8'h02, 8'hFF, 8'h01, 8'h03};
    logic [7:0] gen_rx [5];

    initial begin
        int cnt;
        bit tvp, hs, stray_pend;
        cnt = 0; tvp = 0; stray_pend = 0;
        bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_byte = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                bus.tx_ready = 0; bus.rx_valid = 0; cnt = 0; tvp = 0; stray_pend = 0; drv_nacc = 0;
                continue;
            end
            if (bus.ss_n) drv_nacc = 0;
            hs = bus.tx_ready && tvp;
            bus.rx_valid = 0;
            if (stray_pend) begin
                bus.rx_valid = 1; bus.rx_byte = 8'hEE; stray_pend = 0; stray_cnt++;
            end
            if (hs) begin cnt = 16; drv_nacc++; end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.rx_valid = 1;
                    bus.rx_byte = fixed_rx ? fixed_b[drv_nacc-1] : 8'($urandom);
                    gen_rx[drv_nacc-1] = bus.rx_byte;
                    if (stray_req && drv_nacc < 5) begin stray_pend = 1; stray_req = 0; end
                end
            end
            if (bus.tx_valid && tvp && drv_nacc == stall_byte && stall_len > 0) begin
                stall_len--; bus.tx_ready = 0;
            end else bus.tx_ready = bus.tx_valid && tvp;
            tvp = bus.tx_valid;
        end
    end

    // Reference model: frame events scheduled by absolute edge number.
    int e = 0, fc = 0, tx_at = -1, hold_at = -1, nsent = 0, frames_done = 0;
    int start_edge = 0, prev_start = 0, start_gap = 0, first_tx_edge = 0, last_rx_edge = 0, ss_rise_edge = 0;
    int pos_cnt = 0, led_cnt = 0;
    bit m_active = 0, wait_rx = 0, m_dirty = 1, m_led = 0;
    logic [23:0] m_shadow = 0, m_last = 0;
    logic [7:0] m_rx [5], m_seq [5], act_b [5];
    logic [39:0] done_bytes = 0;
    logic e_ss_n = 1, e_txv = 0, e_pos = 0, e_led = 0;
    logic [7:0] e_txb = 0;
    logic [9:0] e_jx = 0, e_jy = 0;
    logic [1:0] e_btn = 0;
    logic p_rst = 1, p_ready = 0, p_rxv = 0;
    logic [23:0] p_rgb = 0;
    logic [7:0] p_rxb = 0, p_txb = 0;

    always @(negedge clk) begin
        e++;
        e_pos = 0; e_led = 0;
        if (p_rst) begin
            e_ss_n = 1; e_txv = 0; e_txb = 0; e_jx = 0; e_jy = 0; e_btn = 0;
            m_active = 0; wait_rx = 0; fc = 0; m_last = 0; m_dirty = 1; tx_at = -1; hold_at = -1; nsent = 0;
        end else begin
            if (!m_active && fc == 0) begin
                m_active = 1; e_ss_n = 0; nsent = 0; wait_rx = 0; hold_at = -1;
                m_shadow = p_rgb; m_led = m_dirty || p_rgb != m_last;
                m_seq = m_led ? '{8'h84, p_rgb[23:16], p_rgb[15:8], p_rgb[7:0], 8'h00} : '{default: 8'h00};
                tx_at = e + SU;
                start_gap = e - prev_start; prev_start = e; start_edge = e;
            end else if (m_active) begin
                if (e_txv && p_ready) begin
                    e_txv = 0; wait_rx = 1; act_b[nsent] = p_txb;
                end else if (wait_rx && p_rxv) begin
                    m_rx[nsent] = p_rxb; nsent++; wait_rx = 0; last_rx_edge = e;
                    if (nsent < 5) tx_at = e + GP; else hold_at = e + HD;
                end
                if (e == tx_at) begin
                    e_txv = 1; e_txb = m_seq[nsent];
                    if (nsent == 0) first_tx_edge = e;
                end
                if (e == hold_at) begin
                    e_ss_n = 1; m_active = 0; e_pos = 1;
                    e_jx = {m_rx[1][1:0], m_rx[0]}; e_jy = {m_rx[3][1:0], m_rx[2]}; e_btn = m_rx[4][1:0];
                    if (m_led) begin m_last = m_shadow; m_dirty = 0; e_led = 1; end
                    done_bytes = {act_b[0], act_b[1], act_b[2], act_b[3], act_b[4]};
                    ss_rise_edge = e; frames_done++;
                end
            end
            fc = (fc == FC - 1) ? 0 : fc + 1;
        end
        check("ss_n", bus.ss_n, e_ss_n);
        check("tx_valid", bus.tx_valid, e_txv);
        check("tx_byte", bus.tx_byte, e_txb);
        check("busy", busy, m_active);
        check("joy_x", joy_x, e_jx);
        check("joy_y", joy_y, e_jy);
        check("joy_btn", joy_btn, e_btn);
        check("pos_valid", pos_valid, e_pos);
        check("led_sent", led_sent, e_led);
        pos_cnt += int'(pos_valid);
        led_cnt += int'(led_sent);
        p_rst = rst; p_rgb = rgb; p_ready = bus.tx_ready; p_rxv = bus.rx_valid; p_rxb = bus.rx_byte; p_txb = bus.tx_byte;
    end

    task automatic wait_frames(input int n);
        int target, k;
        target = frames_done + n; k = 0;
        while (frames_done < target && k < 3000 * n) begin @(posedge clk); #1; k++; end
        check("frame_timeout", frames_done >= target, 1);
    endtask

    task automatic wait_nacc(input int n);
        int k;
        k = 0;
        while (!(drv_nacc == n && !bus.ss_n) && k < 3000) begin @(posedge clk); #1; k++; end
        check("nacc_timeout", k < 3000, 1);
    endtask

    initial begin
        int pc;
        rgb = 24'h7F0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", bus.ss_n, 1);
        check("rst_busy", busy, 0);
        check("rst_joy", {joy_x, joy_y, joy_btn}, 0);
        rst = 0;
        wait_frames(1);
        check("f1_bytes", done_bytes, 40'h847F000000);
        check("f1_setup", first_tx_edge - start_edge, SU);
        check("f1_hold", ss_rise_edge - last_rx_edge, HD);
        check("f1_led_cnt", led_cnt, 1);
        check("f1_pos_cnt", pos_cnt, 1);
        fixed_rx = 1;
        wait_frames(1);
        fixed_rx = 0;
        check("f2_bytes", done_bytes, 40'h0);
        check("f2_led_cnt", led_cnt, 1);
        check("f2_joy_x", joy_x, 10'h234);
        check("f2_joy_y", joy_y, 10'h1FF);
        check("f2_btn", joy_btn, 2'b11);
        wait_nacc(2);
        rgb = 24'h00007F;
        wait_frames(1);
        check("f3_bytes", done_bytes, 40'h0);
        wait_frames(1);
        check("f4_bytes", done_bytes, 40'h8400007F00);
        check("f4_led_cnt", led_cnt, 2);
        stall_byte = 3; stall_len = 300;
        wait_frames(1);
        stall_byte = -1;
        wait_frames(1);
        check("overrun_gap", start_gap, 2 * FC);
        wait_nacc(3);
        repeat (3) @(posedge clk);
        #1;
        pc = pos_cnt;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("abort_ss_n", bus.ss_n, 1);
        check("abort_joy", {joy_x, joy_y, joy_btn}, 0);
        check("abort_busy", busy, 0);
        wait_frames(1);
        check("abort_pos_cnt", pos_cnt, pc + 1);
        check("abort_led_frame", done_bytes, 40'h8400007F00);
        stray_req = 1;
        wait_frames(1);
        check("stray_seen", stray_cnt, 1);
        check("stray_joy_x", joy_x, {gen_rx[1][1:0], gen_rx[0]});
        check("stray_joy_y", joy_y, {gen_rx[3][1:0], gen_rx[2]});
        check("stray_btn", joy_btn, gen_rx[4][1:0]);
        for (int i = 0; i < 6; i++) begin
            stall_byte = $urandom_range(0, 4);
            stall_len = $urandom_range(0, 20);
            repeat ($urandom_range(0, 350)) @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 1) rgb = 24'($urandom);
            wait_frames(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
